// File: rtl/ed25519_pkg.sv
// Shared Ed25519 field constants, normalizer state encoding and the
// conditional-subtract helper used to bring values below p.
package ed25519_pkg;

    localparam int unsigned FE_W       = 255;  // field element width
    localparam int unsigned T_W        = 257;  // multiplier accumulator width (holds < 4p)
    localparam int unsigned MUL_STEPS  = 85;   // radix-2 reduction steps per multiplier cycle
    localparam int unsigned MUL_DIGITS = 3;    // MUL_STEPS * MUL_DIGITS = 255
    localparam int unsigned MUL_CNT_W  = 2;
    localparam int unsigned BIT_W      = 8;

    localparam logic [255:0] P_256 =
        256'h7fffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffff_ffffffed;
    localparam logic [FE_W-1:0] P        = P_256[FE_W-1:0];
    localparam logic [FE_W-1:0] R2_MOD_P = 255'd361;
    localparam logic [FE_W-1:0] MONT_ONE = 255'd19;
    localparam logic [FE_W-1:0] EXP_PM2  = P - 255'd2;
    // Bit 254 of the exponent is folded into the initial acc = zm.
    localparam logic [BIT_W-1:0] EXP_TOP_BIT = 8'd253;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_TOMONT = 3'd1,
        S_SQR    = 3'd2,
        S_MUL    = 3'd3,
        S_X      = 3'd4,
        S_Y      = 3'd5,
        S_XY     = 3'd6,
        S_DONE   = 3'd7
    } state_t;

    // Reduce a value known to be < 2p into [0, p).
    function automatic logic [FE_W-1:0] mod_sub_p(input logic [255:0] v);
        logic [255:0] diff;
        diff = v - {1'b0, P};
        return (v >= {1'b0, P}) ? diff[FE_W-1:0] : v[FE_W-1:0];
    endfunction

endpackage

// File: rtl/ed25519_mont_mul.sv
// Montgomery multiplier: o_res = i_a * i_b * 2^-255 mod p, canonical.
// Radix-2 interleaved reduction, MUL_STEPS bits per cycle, MUL_DIGITS cycles.
// Operands must be < p; o_finished pulses one cycle with o_res valid.
module ed25519_mont_mul
    import ed25519_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [FE_W-1:0] i_a,
    input  logic [FE_W-1:0] i_b,
    output logic [FE_W-1:0] o_res,
    output logic            o_finished
);

    logic [FE_W-1:0]      a_q, a_d;
    logic [FE_W-1:0]      b_q, b_d;
    logic [T_W-1:0]       t_q, t_d;
    logic [MUL_CNT_W-1:0] cnt_q, cnt_d;
    logic                 busy_q, busy_d;
    logic [FE_W-1:0]      res_q, res_d;
    logic                 fin_q, fin_d;
    logic [T_W-1:0]       t_nxt;

    // One digit of shift-add-reduce per cycle; final conditional subtract.
    always_comb begin
        a_d    = a_q;
        b_d    = b_q;
        t_d    = t_q;
        cnt_d  = cnt_q;
        busy_d = busy_q;
        res_d  = res_q;
        fin_d  = 1'b0;
        t_nxt  = t_q;
        for (int j = 0; j < int'(MUL_STEPS); j++) begin
            if (a_q[j]) t_nxt = t_nxt + {2'b00, b_q};
            if (t_nxt[0]) t_nxt = t_nxt + {2'b00, P};
            t_nxt = t_nxt >> 1;
        end
        if (i_start) begin
            a_d    = i_a;
            b_d    = i_b;
            t_d    = '0;
            cnt_d  = MUL_CNT_W'(MUL_DIGITS - 1);
            busy_d = 1'b1;
        end else if (busy_q) begin
            t_d = t_nxt;
            a_d = a_q >> MUL_STEPS;
            if (cnt_q == '0) begin
                busy_d = 1'b0;
                res_d  = mod_sub_p(t_nxt[255:0]);
                fin_d  = 1'b1;
            end else begin
                cnt_d = cnt_q - MUL_CNT_W'(1);
            end
        end
    end

    // Multiplier state registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            a_q    <= '0;
            b_q    <= '0;
            t_q    <= '0;
            cnt_q  <= '0;
            busy_q <= 1'b0;
            res_q  <= '0;
            fin_q  <= 1'b0;
        end else begin
            a_q    <= a_d;
            b_q    <= b_d;
            t_q    <= t_d;
            cnt_q  <= cnt_d;
            busy_q <= busy_d;
            res_q  <= res_d;
            fin_q  <= fin_d;
        end
    end

    assign o_res      = res_q;
    assign o_finished = fin_q;

endmodule

// File: rtl/point_normalize.sv
// Extended (X:Y:Z) to affine (x, y) conversion with compressed encoding.
// Z^-1 = Z^(p-2) by square-and-multiply on a shared Montgomery multiplier.
// Optional build macro POINT_NORMALIZE_DUAL_MUL_EN adds a second multiplier
// so the final x and y products run in parallel (state S_XY).
module point_normalize
    import ed25519_pkg::*;
(
    input  logic            i_clk,
    input  logic            i_rst,
    input  logic            i_start,
    input  logic [FE_W-1:0] i_x,
    input  logic [FE_W-1:0] i_y,
    input  logic [FE_W-1:0] i_z,
    output logic [FE_W-1:0] o_x,
    output logic [FE_W-1:0] o_y,
    output logic [FE_W:0]   o_enc,
    output logic            o_invalid,
    output logic            o_busy,
    output logic            o_finished
);

`ifdef POINT_NORMALIZE_DUAL_MUL_EN
    localparam state_t S_AFTER_EXP = S_XY;
`else
    localparam state_t S_AFTER_EXP = S_X;
`endif

    state_t           state_q, state_d;
    logic [BIT_W-1:0] bit_q, bit_d;
    logic [FE_W-1:0]  x_q, x_d, y_q, y_d, z_q, z_d;
    logic [FE_W-1:0]  zm_q, zm_d, acc_q, acc_d;
    logic [FE_W-1:0]  rx_q, rx_d, ry_q, ry_d;
    logic             wait_q, wait_d;
    logic             mul_start_q, mul_start_d;
    logic [FE_W-1:0]  mul_a_q, mul_a_d, mul_b_q, mul_b_d;
    logic [FE_W-1:0]  ox_q, ox_d, oy_q, oy_d;
    logic             inv_q, inv_d, busy_q, busy_d, fin_q, fin_d;
    logic [FE_W-1:0]  mul_res;
    logic             mul_fin;
    logic             mul_done;

    ed25519_mont_mul u_mul (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mul_start_q),
        .i_a        (mul_a_q),
        .i_b        (mul_b_q),
        .o_res      (mul_res),
        .o_finished (mul_fin)
    );

`ifdef POINT_NORMALIZE_DUAL_MUL_EN
    logic [FE_W-1:0] mul2_a_q, mul2_a_d, mul2_b_q, mul2_b_d;
    logic [FE_W-1:0] mul2_res;
    logic            mul2_fin;

    ed25519_mont_mul u_mul2 (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_start    (mul_start_q),
        .i_a        (mul2_a_q),
        .i_b        (mul2_b_q),
        .o_res      (mul2_res),
        .o_finished (mul2_fin)
    );

    assign mul_done = mul_fin & mul2_fin;
`else
    assign mul_done = mul_fin;
`endif

    // Sequencer: each multiply state issues once, then waits for the result.
    always_comb begin
        state_d     = state_q;
        bit_d       = bit_q;
        x_d         = x_q;
        y_d         = y_q;
        z_d         = z_q;
        zm_d        = zm_q;
        acc_d       = acc_q;
        rx_d        = rx_q;
        ry_d        = ry_q;
        wait_d      = wait_q;
        mul_start_d = 1'b0;
        mul_a_d     = mul_a_q;
        mul_b_d     = mul_b_q;
        ox_d        = ox_q;
        oy_d        = oy_q;
        inv_d       = inv_q;
        busy_d      = busy_q;
        fin_d       = 1'b0;
`ifdef POINT_NORMALIZE_DUAL_MUL_EN
        mul2_a_d    = mul2_a_q;
        mul2_b_d    = mul2_b_q;
`endif
        case (state_q)
            S_IDLE: begin
                if (i_start) begin
                    x_d     = i_x;
                    y_d     = i_y;
                    z_d     = i_z;
                    acc_d   = MONT_ONE;
                    bit_d   = EXP_TOP_BIT;
                    wait_d  = 1'b0;
                    inv_d   = 1'b0;
                    busy_d  = 1'b1;
                    state_d = S_TOMONT;
                end
            end
            S_TOMONT: begin
                if (!wait_q) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = z_q;
                    mul_b_d     = R2_MOD_P;
                    wait_d      = 1'b1;
                end else if (mul_done) begin
                    wait_d  = 1'b0;
                    zm_d    = mul_res;
                    acc_d   = mul_res;
                    state_d = S_SQR;
                end
            end
            S_SQR: begin
                if (!wait_q) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = acc_q;
                    mul_b_d     = acc_q;
                    wait_d      = 1'b1;
                end else if (mul_done) begin
                    wait_d = 1'b0;
                    acc_d  = mul_res;
                    if (EXP_PM2[bit_q]) begin
                        state_d = S_MUL;
                    end else if (bit_q == '0) begin
                        state_d = S_AFTER_EXP;
                    end else begin
                        bit_d = bit_q - BIT_W'(1);
                    end
                end
            end
            S_MUL: begin
                if (!wait_q) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = acc_q;
                    mul_b_d     = zm_q;
                    wait_d      = 1'b1;
                end else if (mul_done) begin
                    wait_d = 1'b0;
                    acc_d  = mul_res;
                    if (bit_q == '0) begin
                        state_d = S_AFTER_EXP;
                    end else begin
                        bit_d   = bit_q - BIT_W'(1);
                        state_d = S_SQR;
                    end
                end
            end
`ifdef POINT_NORMALIZE_DUAL_MUL_EN
            S_XY: begin
                if (!wait_q) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = x_q;
                    mul_b_d     = acc_q;
                    mul2_a_d    = y_q;
                    mul2_b_d    = acc_q;
                    wait_d      = 1'b1;
                end else if (mul_done) begin
                    wait_d  = 1'b0;
                    rx_d    = mul_res;
                    ry_d    = mul2_res;
                    state_d = S_DONE;
                end
            end
`else
            S_X: begin
                if (!wait_q) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = x_q;
                    mul_b_d     = acc_q;
                    wait_d      = 1'b1;
                end else if (mul_done) begin
                    wait_d  = 1'b0;
                    rx_d    = mul_res;
                    state_d = S_Y;
                end
            end
            S_Y: begin
                if (!wait_q) begin
                    mul_start_d = 1'b1;
                    mul_a_d     = y_q;
                    mul_b_d     = acc_q;
                    wait_d      = 1'b1;
                end else if (mul_done) begin
                    wait_d  = 1'b0;
                    ry_d    = mul_res;
                    state_d = S_DONE;
                end
            end
`endif
            S_DONE: begin
                ox_d    = mod_sub_p({1'b0, rx_q});
                oy_d    = mod_sub_p({1'b0, ry_q});
                inv_d   = (z_q == '0);
                fin_d   = 1'b1;
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    // Sequencer and output registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            bit_q       <= '0;
            x_q         <= '0;
            y_q         <= '0;
            z_q         <= '0;
            zm_q        <= '0;
            acc_q       <= '0;
            rx_q        <= '0;
            ry_q        <= '0;
            wait_q      <= 1'b0;
            mul_start_q <= 1'b0;
            mul_a_q     <= '0;
            mul_b_q     <= '0;
            ox_q        <= '0;
            oy_q        <= '0;
            inv_q       <= 1'b0;
            busy_q      <= 1'b0;
            fin_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            bit_q       <= bit_d;
            x_q         <= x_d;
            y_q         <= y_d;
            z_q         <= z_d;
            zm_q        <= zm_d;
            acc_q       <= acc_d;
            rx_q        <= rx_d;
            ry_q        <= ry_d;
            wait_q      <= wait_d;
            mul_start_q <= mul_start_d;
            mul_a_q     <= mul_a_d;
            mul_b_q     <= mul_b_d;
            ox_q        <= ox_d;
            oy_q        <= oy_d;
            inv_q       <= inv_d;
            busy_q      <= busy_d;
            fin_q       <= fin_d;
        end
    end

`ifdef POINT_NORMALIZE_DUAL_MUL_EN
    // Second multiplier operand registers.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            mul2_a_q <= '0;
            mul2_b_q <= '0;
        end else begin
            mul2_a_q <= mul2_a_d;
            mul2_b_q <= mul2_b_d;
        end
    end
`endif

    assign o_x        = ox_q;
    assign o_y        = oy_q;
    assign o_enc      = {ox_q[0], oy_q};
    assign o_invalid  = inv_q;
    assign o_busy     = busy_q;
    assign o_finished = fin_q;

endmodule

// File: tb/tb_point_normalize.sv
// Scoreboard bench for point_normalize: stimulus pushes expected affine
// results, a negedge monitor pops and compares on every o_finished.
module tb_point_normalize;

    localparam logic [255:0] TB_P = (256'd1 << 255) - 256'd19;
    localparam int LIMIT = 8000;

    logic         clk = 1'b0;
    logic         i_rst = 1'b1;
    logic         i_start = 1'b0;
    logic [254:0] i_x = '0, i_y = '0, i_z = '0;
    logic [254:0] o_x, o_y;
    logic [255:0] o_enc;
    logic         o_invalid, o_busy, o_finished;

    typedef struct {
        logic [254:0] x;
        logic [254:0] y;
        logic         inv;
    } exp_t;

    exp_t exp_q[$];
    int   tests = 0;
    int   fails = 0;
    int   fin_cnt = 0;
    int   start_cnt = 0;

    always #5 clk = ~clk;

    point_normalize dut (
        .i_clk      (clk),
        .i_rst      (i_rst),
        .i_start    (i_start),
        .i_x        (i_x),
        .i_y        (i_y),
        .i_z        (i_z),
        .o_x        (o_x),
        .o_y        (o_y),
        .o_enc      (o_enc),
        .o_invalid  (o_invalid),
        .o_busy     (o_busy),
        .o_finished (o_finished)
    );

    task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic logic [254:0] mulmod(input logic [254:0] a, input logic [254:0] b);
        logic [509:0] pr;
        pr = {255'd0, a} * {255'd0, b};
        pr = pr % {254'd0, TB_P};
        return pr[254:0];
    endfunction

    function automatic logic [254:0] rand_fe();
        logic [255:0] v;
        v = '0;
        for (int k = 0; k < 8; k++) v = {v[223:0], 32'($urandom())};
        v[255] = 1'b0;
        v = v % TB_P;
        return v[254:0];
    endfunction

    // Monitor: every finish must match the oldest outstanding expectation.
    always @(negedge clk) begin
        exp_t e;
        if (dut.mul_start_q) start_cnt++;
        if (o_finished) begin
            fin_cnt++;
            if (exp_q.size() == 0) begin
                check("unexpected_finish", 256'(o_finished), 256'd0);
            end else begin
                e = exp_q.pop_front();
                check("o_x", {1'b0, o_x}, {1'b0, e.x});
                check("o_y", {1'b0, o_y}, {1'b0, e.y});
                check("o_enc", o_enc, {e.x[0], e.y});
                check("o_invalid", 256'(o_invalid), 256'(e.inv));
            end
        end
    end

    task automatic pulse_start(input logic [254:0] x, input logic [254:0] y, input logic [254:0] z);
        @(negedge clk);
        i_x = x; i_y = y; i_z = z; i_start = 1'b1;
        @(negedge clk);
        i_start = 1'b0;
    endtask

    task automatic wait_finish(input string name);
        int n;
        n = 0;
        while (!o_finished && n < LIMIT) begin
            @(negedge clk);
            n++;
        end
        check({"done_", name}, 256'(o_finished), 256'd1);
        @(negedge clk);
    endtask

    task automatic run_op(input string name,
                          input logic [254:0] x, input logic [254:0] y, input logic [254:0] z,
                          input logic [254:0] ex, input logic [254:0] ey, input logic einv);
        exp_t e;
        e.x = ex; e.y = ey; e.inv = einv;
        exp_q.push_back(e);
        pulse_start(x, y, z);
        check({"busy_", name}, 256'(o_busy), 256'd1);
        wait_finish(name);
        check({"idle_", name}, 256'(o_busy), 256'd0);
    endtask

    initial begin
        logic [255:0] bx256, by256;
        logic [254:0] bx, by, pm1, ax, ay, az;
        int f0, exp_starts;
        exp_t e;

        bx256 = 256'h216936d3_cd6e53fe_c0a4e231_fdd6dc5c_692cc760_9525a7b2_c9562d60_8f25d51a;
        by256 = 256'h66666666_66666666_66666666_66666666_66666666_66666666_66666666_66666658;
        bx  = bx256[254:0];
        by  = by256[254:0];
        pm1 = 255'(TB_P - 256'd1);

        repeat (3) @(negedge clk);
        check("rst_o_x", {1'b0, o_x}, 256'd0);
        check("rst_o_y", {1'b0, o_y}, 256'd0);
        check("rst_o_enc", o_enc, 256'd0);
        check("rst_busy", 256'(o_busy), 256'd0);
        check("rst_fin", 256'(o_finished), 256'd0);
        check("rst_inv", 256'(o_invalid), 256'd0);
        i_rst = 1'b0;
        @(negedge clk);

        run_op("unit_z", 255'd5, 255'd7, 255'd1, 255'd5, 255'd7, 1'b0);
        run_op("z_two", 255'd4, 255'd6, 255'd2, 255'd2, 255'd3, 1'b0);
        run_op("z_pm1", 255'd1, 255'd1, pm1, pm1, pm1, 1'b0);
        run_op("z_zero", 255'd5, 255'd5, 255'd0, 255'd0, 255'd0, 1'b1);

        start_cnt = 0;
        run_op("base_pt", mulmod(bx, 255'd3), mulmod(by, 255'd3), 255'd3, bx, by, 1'b0);
`ifdef POINT_NORMALIZE_DUAL_MUL_EN
        exp_starts = 508;
`else
        exp_starts = 509;
`endif
        check("mul_issues", 256'(start_cnt), 256'(exp_starts));

        // Random affine points scaled by random Z; expect the points back.
        for (int r = 0; r < 6; r++) begin
            ax = rand_fe(); ay = rand_fe(); az = rand_fe();
            if (az == '0) az = 255'd1;
            run_op("rand", mulmod(ax, az), mulmod(ay, az), az, ax, ay, 1'b0);
        end
        ax = rand_fe(); ay = rand_fe();
        run_op("rand_z0", ax, ay, 255'd0, 255'd0, 255'd0, 1'b1);

        // A second start mid-run must be ignored.
        f0 = fin_cnt;
        e.x = 255'd5; e.y = 255'd7; e.inv = 1'b0;
        exp_q.push_back(e);
        pulse_start(255'd5, 255'd7, 255'd1);
        repeat (50) @(negedge clk);
        pulse_start(255'd4, 255'd6, 255'd2);
        wait_finish("ignored_start");
        repeat (3) @(negedge clk);
        check("single_finish", 256'(fin_cnt - f0), 256'd1);
        check("idle_after_ignored", 256'(o_busy), 256'd0);

        // Reset mid-run aborts with cleared outputs and no finish.
        f0 = fin_cnt;
        pulse_start(mulmod(255'd9, 255'd11), mulmod(255'd13, 255'd11), 255'd11);
        repeat (300) @(negedge clk);
        i_rst = 1'b1;
        repeat (2) @(negedge clk);
        i_rst = 1'b0;
        check("abort_o_x", {1'b0, o_x}, 256'd0);
        check("abort_o_y", {1'b0, o_y}, 256'd0);
        check("abort_o_enc", o_enc, 256'd0);
        check("abort_busy", 256'(o_busy), 256'd0);
        check("abort_inv", 256'(o_invalid), 256'd0);
        repeat (3000) @(negedge clk);
        check("abort_no_finish", 256'(fin_cnt - f0), 256'd0);
        run_op("after_reset", mulmod(255'd9, 255'd11), mulmod(255'd13, 255'd11), 255'd11,
               255'd9, 255'd13, 1'b0);

        check("queue_drained", 256'(exp_q.size()), 256'd0);
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
